// File: rtl/fb_scanout_dma.sv
// Framebuffer scanout: burst-reads RGB888 words into a pixel FIFO and emits one 30-bit Avalon-ST packet per frame.
// Latency: first m_read 2 cycles after enable rises; first st_valid 1 cycle after the first m_readdatavalid.
// Backpressure: st_ready stalls the FIFO head; a burst issues only when free FIFO space covers every outstanding beat.
module fb_scanout_dma #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_burstcount,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [29:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              underflow,
  output logic              frame_done
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FC_W  = AW + 1;

  localparam logic [CNT_W-1:0]  L_TOTAL     = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  L_LAST_REQ  = CNT_W'(TOTAL - BURST_LEN);
  localparam logic [CNT_W-1:0]  L_LAST_PIX  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  L_BURST_C   = CNT_W'(BURST_LEN);
  localparam logic [FC_W-1:0]   L_BURST_F   = FC_W'(BURST_LEN);
  localparam logic [FC_W-1:0]   L_DEPTH     = FC_W'(FIFO_DEPTH);
  localparam logic [FC_W:0]     L_USED_MAX  = (FC_W+1)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_W-1:0] L_ADDR_STEP = ADDR_W'(4 * BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_next_addr;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [FC_W-1:0]    r_outstanding;
  logic               r_underflow;
  logic               r_frame_done;

  logic [29:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [FC_W-1:0]    r_fifo_count;

  logic [FC_W:0]      w_used;
  logic               w_credit_ok;
  logic               w_req_more;
  logic               w_accept;
  logic               w_last_burst;
  logic               w_push;
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic               w_fifo_vld;
  logic [29:0]        w_push_dat;
  logic               w_xfer;
  logic               w_eop_xfer;
  logic               w_active;
  logic               w_unused_rd;

  function automatic logic [9:0] f_exp10(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  // Command side: credit counts FIFO entries plus beats still in flight
  assign w_used       = {1'b0, r_fifo_count} + {1'b0, r_outstanding};
  assign w_credit_ok  = (w_used <= L_USED_MAX);
  assign w_req_more   = (r_req_cnt < L_TOTAL);
  assign w_last_burst = (r_req_cnt == L_LAST_REQ);
  assign m_read       = (r_state == S_FETCH) && w_req_more && w_credit_ok;
  assign w_accept     = m_read && !m_waitrequest;
  assign m_address    = r_next_addr;
  assign m_burstcount = m_read ? 4'(BURST_LEN) : 4'd0;

  // Read-data side: beats with nothing outstanding (stale after reset) are dropped
  assign w_push      = m_readdatavalid && (r_outstanding != '0);
  assign w_fifo_push = w_push && (r_fifo_count != L_DEPTH);
  assign w_push_dat  = {f_exp10(m_readdata[23:16]), f_exp10(m_readdata[15:8]), f_exp10(m_readdata[7:0])};
  assign w_unused_rd = ^m_readdata[31:24];

  // Stream side: head of FIFO is presented directly
  assign w_fifo_vld = (r_fifo_count != '0);
  assign st_valid   = w_fifo_vld;
  assign st_data    = w_fifo_vld ? r_mem[r_rd_ptr] : 30'd0;
  assign st_sop     = w_fifo_vld && (r_out_cnt == '0);
  assign st_eop     = w_fifo_vld && (r_out_cnt == L_LAST_PIX);
  assign w_xfer     = st_valid && st_ready;
  assign w_fifo_pop = w_xfer;
  assign w_eop_xfer = w_xfer && st_eop;
  assign w_active   = (r_state == S_FETCH) || (r_state == S_DRAIN);

  assign underflow  = r_underflow;
  assign frame_done = r_frame_done;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: a frame, once armed, always runs through its EOP beat
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_FETCH;
      S_FETCH: if (w_accept && w_last_burst) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_eop_xfer) w_state_nxt = enable ? S_ARM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address and request counter: base latched only in ARM, advanced per accepted burst
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_next_addr <= '0;
      r_req_cnt   <= '0;
    end else if (r_state == S_ARM) begin
      r_next_addr <= fb_base;
      r_req_cnt   <= '0;
    end else if (w_accept) begin
      r_next_addr <= r_next_addr + L_ADDR_STEP;
      r_req_cnt   <= r_req_cnt + L_BURST_C;
    end
  end

  // Outstanding beats: grows by a burst on accept, shrinks per returned beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_accept, w_push})
        2'b10:   r_outstanding <= r_outstanding + L_BURST_F;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        2'b11:   r_outstanding <= r_outstanding + L_BURST_F - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Output pixel counter drives SOP/EOP marking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_out_cnt <= '0;
    else if (r_state == S_ARM)  r_out_cnt <= '0;
    else if (w_xfer)            r_out_cnt <= r_out_cnt + 1'b1;
  end

  // FIFO storage, no reset needed since valid comes from the count
  always_ff @(posedge clk) begin
    if (w_fifo_push) r_mem[r_wr_ptr] <= w_push_dat;
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_fifo_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fifo_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_fifo_push, w_fifo_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Sticky underflow and frame-done pulse one cycle after the EOP beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_active && st_ready && !w_fifo_vld) r_underflow <= 1'b1;
      r_frame_done <= (r_state == S_DRAIN) && w_eop_xfer;
    end
  end

endmodule

// File: tb/tb_fb_scanout_dma.sv
// Bench for fb_scanout_dma with a small 4x2 frame, Avalon-MM slave model and pixel scoreboard.
// Latency: slave returns data a configurable number of cycles after each accepted command.
// Backpressure: st_ready and m_waitrequest are driven by directed steps.
module tb_fb_scanout_dma;

  localparam int BL   = 4;
  localparam int FD   = 8;
  localparam int NPIX = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] fb_base;
  logic [31:0] m_address;
  logic [3:0]  m_burstcount;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = 32'd0;
  logic        m_readdatavalid = 1'b0;
  logic [29:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;
  logic        underflow;
  logic        frame_done;

  typedef struct { logic [29:0] d; logic sop; logic eop; } pix_t;
  typedef struct { int due; logic [31:0] w; } beat_t;

  pix_t        sb[$];
  beat_t       pend[$];
  pix_t        e;
  logic [31:0] w;
  logic [31:0] exp_base = 32'h1000;
  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          lat = 2;
  int          stall_req = 0;
  int          stall_seen = 0;
  int          acc_bursts = 0;
  int          beats = 0;
  int          fd_cnt = 0;
  int          max_res = 0;
  int          push_idx = 0;
  logic        eop_prev = 1'b0;

  always #5 clk = ~clk;

  fb_scanout_dma #(
    .H_RES(4), .V_RES(2), .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fb_base(fb_base),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop),
    .underflow(underflow), .frame_done(frame_done)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h1000) return 32'h00FF8000;
    return {8'hC3, a[7:0], ~a[9:2], a[7:0] ^ 8'h5A};
  endfunction

  function automatic logic [9:0] x10(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 500) begin
      tick(1);
      n++;
    end
    check("frame_done_seen", 32'(fd_cnt >= target), 32'd1);
  endtask

  // Slave model plus stream monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      pend.delete();
      sb.delete();
      acc_bursts = 0; beats = 0; fd_cnt = 0; max_res = 0;
      push_idx = 0; stall_seen = 0; eop_prev = 1'b0;
      m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    end else begin
      ncyc++;
      if (frame_done || eop_prev) check("frame_done_pulse", 32'(frame_done), 32'(eop_prev));
      if (frame_done) fd_cnt++;
      eop_prev = 1'b0;
      if (st_valid && st_ready) begin
        beats++;
        if (sb.size() == 0) begin
          check("sb_underrun", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("st_data", 32'(st_data), 32'(e.d));
          check("st_sop", 32'(st_sop), 32'(e.sop));
          check("st_eop", 32'(st_eop), 32'(e.eop));
        end
        eop_prev = st_eop;
      end
      if (acc_bursts * BL - beats > max_res) max_res = acc_bursts * BL - beats;
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        m_readdatavalid = 1'b1;
        m_readdata      = pend[0].w;
        void'(pend.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = 32'hDEADBEEF;
      end
      if (m_read) begin
        check("cmd_addr", m_address, exp_base + 32'(4 * push_idx));
        check("cmd_burstcount", 32'(m_burstcount), 32'(BL));
        if (stall_seen < stall_req) begin
          m_waitrequest = 1'b1;
          stall_seen++;
        end else begin
          m_waitrequest = 1'b0;
          acc_bursts++;
          for (int i = 0; i < BL; i++) begin
            w = memw(exp_base + 32'(4 * push_idx));
            pend.push_back('{due: ncyc + lat + i, w: w});
            sb.push_back('{d: {x10(w[23:16]), x10(w[15:8]), x10(w[7:0])},
                           sop: (push_idx == 0), eop: (push_idx == NPIX - 1)});
            push_idx = (push_idx + 1) % NPIX;
          end
        end
      end else begin
        m_waitrequest = 1'b0;
      end
    end
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    enable   = 1'b0;
    fb_base  = 32'h1000;
    st_ready = 1'b0;
    tick(3);

    // Reset state
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_burstcount", 32'(m_burstcount), 32'd0);
    check("rst_st_valid", 32'(st_valid), 32'd0);
    check("rst_st_data", 32'(st_data), 32'd0);
    check("rst_sop_eop", 32'({st_sop, st_eop}), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Basic frame, zero-wait slave, downstream always ready
    reset_n  = 1'b1;
    st_ready = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(1);
    check("lat_arm_no_read", 32'(m_read), 32'd0);
    tick(1);
    check("lat_fetch_read", 32'(m_read), 32'd1);
    check("first_addr", m_address, 32'h1000);
    enable = 1'b0;
    n = 0;
    while (!st_valid && n < 100) begin
      tick(1);
      n++;
    end
    check("first_valid_seen", 32'(st_valid), 32'd1);
    check("expand_00FF8000", 32'(st_data), 32'h3FF80800);
    wait_fd(1);
    tick(20);
    check("t1_bursts", 32'(acc_bursts), 32'd2);
    check("t1_beats", 32'(beats), 32'd8);
    check("t1_frame_done_cnt", 32'(fd_cnt), 32'd1);
    check("t1_idle_no_read", 32'(m_read), 32'd0);

    // First command held under waitrequest for 5 cycles
    do_reset();
    stall_req = 5;
    enable = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      check("wr_hold_read", 32'(m_read), 32'd1);
      check("wr_hold_addr", m_address, 32'h1000);
      tick(1);
    end
    check("wr_stall_cycles", 32'(stall_seen), 32'd5);
    check("wr_accepted", 32'(acc_bursts), 32'd1);
    check("wr_next_addr", m_address, 32'h1010);
    enable = 1'b0;
    wait_fd(1);
    tick(5);
    check("wr_beats", 32'(beats), 32'd8);
    stall_req = 0;

    // Downstream stalled: FIFO fills, credit stops further bursts
    do_reset();
    st_ready = 1'b0;
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    tick(50);
    check("bp_bursts", 32'(acc_bursts), 32'd2);
    check("bp_reserved_le_depth", 32'(max_res <= FD), 32'd1);
    check("bp_valid_held", 32'(st_valid), 32'd1);
    check("bp_sop_held", 32'(st_sop), 32'd1);
    check("bp_data_held", 32'(st_data), 32'(sb[0].d));
    check("bp_no_frame_done", 32'(fd_cnt), 32'd0);
    st_ready = 1'b1;
    wait_fd(1);
    tick(10);
    check("bp_beats", 32'(beats), 32'd8);
    check("bp_no_underflow", 32'(underflow), 32'd0);
    check("bp_idle_no_read", 32'(m_read), 32'd0);

    // Enable dropped mid-frame, fb_base change ignored until next arm
    do_reset();
    st_ready = 1'b1;
    enable = 1'b1;
    n = 0;
    while (beats < 3 && n < 200) begin
      tick(1);
      n++;
    end
    check("mf_beat2_seen", 32'(beats >= 3), 32'd1);
    enable  = 1'b0;
    fb_base = 32'h2000;
    wait_fd(1);
    tick(20);
    check("mf_bursts", 32'(acc_bursts), 32'd2);
    check("mf_beats", 32'(beats), 32'd8);
    check("mf_frame_done_cnt", 32'(fd_cnt), 32'd1);
    check("mf_idle_no_read", 32'(m_read), 32'd0);
    fb_base  = 32'h3000;
    exp_base = 32'h3000;
    enable = 1'b1;
    tick(2);
    check("rearm_read", 32'(m_read), 32'd1);
    check("rearm_addr", m_address, 32'h3000);
    enable = 1'b0;
    wait_fd(2);
    tick(10);
    check("rearm_bursts", 32'(acc_bursts), 32'd4);
    check("rearm_beats", 32'(beats), 32'd16);

    // Slow read data with ready downstream: sticky underflow
    do_reset();
    fb_base  = 32'h1000;
    exp_base = 32'h1000;
    lat = 10;
    st_ready = 1'b1;
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    wait_fd(1);
    tick(5);
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_beats", 32'(beats), 32'd8);
    tick(5);
    check("uf_sticky", 32'(underflow), 32'd1);
    reset_n = 1'b0;
    #1;
    check("uf_reset_clear", 32'(underflow), 32'd0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
